demux_1a4_buffered: RTL and testbench

//  Registered 1-to-4 demultiplexer with a valid/ready handshake on every channel.
//  It is the distribution counterpart of the 4-to-1 selection mux: one producer word is routed to
//  one of four consumers chosen by Selector.

---
 rtl/demux_1a4_buffered.sv | 130 +++++++++++++
 tb/tb_demux_1a4_buffered.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1a4_buffered.sv
// Registered 1-to-4 demultiplexer with per-channel valid/ready handshake and one-word buffers.
// Optional per-channel saturating transfer counters are enabled by defining DEMUX_COUNT_EN.
module demux_1a4_buffered #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [1:0]             Selector,
    input  logic                   In_valid,
    output logic                   In_ready,
    input  logic [WIDTH-1:0]       In_data,
    output logic [3:0]             Out_valid,
    input  logic [3:0]             Out_ready,
    output logic [WIDTH-1:0]       Out_data0,
    output logic [WIDTH-1:0]       Out_data1,
    output logic [WIDTH-1:0]       Out_data2,
    output logic [WIDTH-1:0]       Out_data3
`ifdef DEMUX_COUNT_EN
    ,
    input  logic                   Clear_counts,
    output logic [COUNT_WIDTH-1:0] Count0,
    output logic [COUNT_WIDTH-1:0] Count1,
    output logic [COUNT_WIDTH-1:0] Count2,
    output logic [COUNT_WIDTH-1:0] Count3
`endif
);

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_t;

    logic                 accept;
    logic [3:0]           load;
    logic [WIDTH-1:0]     ch_data [4];

    // A full channel can still take a word if its consumer drains it in the same cycle.
    assign In_ready = ~Out_valid[Selector] | Out_ready[Selector];
    assign accept   = In_valid & In_ready;

    always_comb begin
        load = 4'b0000;
        if (accept) begin
            load[Selector] = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ch
            ch_state_t        state_q, state_d;
            logic [WIDTH-1:0] data_q, data_d;

            always_comb begin
                state_d = state_q;
                data_d  = data_q;
                case (state_q)
                    CH_EMPTY: begin
                        if (load[gi]) begin
                            state_d = CH_FULL;
                            data_d  = In_data;
                        end
                    end
                    CH_FULL: begin
                        if (load[gi]) begin
                            data_d = In_data;
                        end else if (Out_ready[gi]) begin
                            state_d = CH_EMPTY;
                        end
                    end
                    default: state_d = CH_EMPTY;
                endcase
            end

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    state_q <= CH_EMPTY;
                    data_q  <= '0;
                end else begin
                    state_q <= state_d;
                    data_q  <= data_d;
                end
            end

            assign Out_valid[gi] = (state_q == CH_FULL);
            assign ch_data[gi]   = data_q;
        end
    endgenerate

    assign Out_data0 = ch_data[0];
    assign Out_data1 = ch_data[1];
    assign Out_data2 = ch_data[2];
    assign Out_data3 = ch_data[3];

`ifdef DEMUX_COUNT_EN
    logic [COUNT_WIDTH-1:0] cnt [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
            logic [COUNT_WIDTH-1:0] count_q, count_d;

            // Clear wins over a same-cycle increment; the count sticks at all-ones.
            always_comb begin
                count_d = count_q;
                if (Clear_counts) begin
                    count_d = '0;
                end else if (load[gi] && (count_q != {COUNT_WIDTH{1'b1}})) begin
                    count_d = count_q + 1'b1;
                end
            end

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign cnt[gi] = count_q;
        end
    endgenerate

    assign Count0 = cnt[0];
    assign Count1 = cnt[1];
    assign Count2 = cnt[2];
    assign Count3 = cnt[3];
`endif

endmodule

// File: tb/tb_demux_1a4_buffered.sv
// Self-checking bench for demux_1a4_buffered: vector table, scoreboard of routed words,
// and hand-written sequences for replace-on-drain, streaming, async reset and counters.
`timescale 1ns/1ps
module tb_demux_1a4_buffered;

    localparam int W  = 8;
    localparam int CW = 2;

    logic          clk;
    logic          rst_n;
    logic [1:0]    sel;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [W-1:0]  od0, od1, od2, od3;
`ifdef DEMUX_COUNT_EN
    logic          clear_counts;
    logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;
`endif

    demux_1a4_buffered #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .Selector  (sel),
        .In_valid  (in_valid),
        .In_ready  (in_ready),
        .In_data   (in_data),
        .Out_valid (out_valid),
        .Out_ready (out_ready),
        .Out_data0 (od0),
        .Out_data1 (od1),
        .Out_data2 (od2),
        .Out_data3 (od3)
`ifdef DEMUX_COUNT_EN
        ,
        .Clear_counts (clear_counts),
        .Count0       (cnt0),
        .Count1       (cnt1),
        .Count2       (cnt2),
        .Count3       (cnt3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   ch;
        logic [W-1:0] data;
    } sb_t;

    typedef struct {
        logic [1:0]   sel;
        logic         iv;
        logic [W-1:0] d;
        logic [3:0]   ordy;
        logic         exp_ir;
        logic [3:0]   exp_ov;
        logic [W-1:0] exp_dsel;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[7];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    function automatic logic [W-1:0] get_data(input logic [1:0] ch);
        case (ch)
            2'd0:    return od0;
            2'd1:    return od1;
            2'd2:    return od2;
            default: return od3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] s, input logic iv, input logic [W-1:0] d,
                         input logic [3:0] ordy);
        sel       = s;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    // Record handshakes seen before the edge (drains first, then the accept), then advance.
    task automatic tick();
        #1;
        for (int ch = 0; ch < 4; ch++) begin
            if (out_valid[ch] && out_ready[ch]) begin
                int idx = -1;
                for (int k = 0; k < sb.size(); k++) begin
                    if (idx < 0 && sb[k].ch == 2'(ch)) idx = k;
                end
                if (idx < 0) begin
                    check($sformatf("sb_unexpected_ch%0d", ch), 32'(get_data(2'(ch))), 32'hDEAD);
                end else begin
                    check($sformatf("sb_data_ch%0d", ch), 32'(get_data(2'(ch))), 32'(sb[idx].data));
                    sb.delete(idx);
                end
            end
        end
        if (in_valid && in_ready) begin
            sb.push_back('{ch: sel, data: in_data});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(2'd0, 1'b0, '0, 4'b0000);
`ifdef DEMUX_COUNT_EN
        clear_counts = 1'b0;
`endif
        tbl[0] = '{2'd2, 1'b1, 8'hA5, 4'b0000, 1'b1, 4'b0100, 8'hA5};
        tbl[1] = '{2'd1, 1'b1, 8'hB1, 4'b0000, 1'b1, 4'b0110, 8'hB1};
        tbl[2] = '{2'd1, 1'b1, 8'hC3, 4'b0000, 1'b0, 4'b0110, 8'hB1};
        tbl[3] = '{2'd3, 1'b1, 8'hC3, 4'b0000, 1'b1, 4'b1110, 8'hC3};
        tbl[4] = '{2'd3, 1'b1, 8'hD4, 4'b1000, 1'b1, 4'b1110, 8'hD4};
        tbl[5] = '{2'd0, 1'b0, 8'h00, 4'b0110, 1'b1, 4'b1000, 8'h00};
        tbl[6] = '{2'd3, 1'b0, 8'h00, 4'b1000, 1'b1, 4'b0000, 8'hD4};

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_data", {od3, od2, od1, od0}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'h1);

        // Table: single route, stall with selector switch, replace-on-drain, drains.
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].sel, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_ir));
            tick();
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
            check($sformatf("vec%0d_data", i), 32'(get_data(tbl[i].sel)), 32'(tbl[i].exp_dsel));
            $display("vec%0d sel=%0d iv=%0b d=%02h ordy=%04b -> ov=%04b", i, tbl[i].sel,
                     tbl[i].iv, tbl[i].d, tbl[i].ordy, out_valid);
        end

        // Channel 0 holds 11 and drains while 22 is accepted in the same cycle.
        drive(2'd0, 1'b1, 8'h11, 4'b0000);
        tick();
        drive(2'd0, 1'b1, 8'h22, 4'b0001);
        #1;
        check("repl_in_ready", 32'(in_ready), 32'h1);
        tick();
        check("repl_out_valid", 32'(out_valid), 32'h1);
        check("repl_data0", 32'(od0), 32'h22);
        drive(2'd0, 1'b0, '0, 4'b0001);
        tick();
        check("repl_drained", 32'(out_valid), 32'h0);

        // Streaming one word per cycle to channels 0..3 with every consumer ready.
        for (int i = 0; i < 4; i++) begin
            drive(2'(i), 1'b1, 8'(i + 1), 4'b1111);
            #1;
            check($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'h1);
            tick();
            check($sformatf("stream%0d_out_valid", i), 32'(out_valid), 32'(4'b0001 << i));
            $display("stream word %0d -> ch%0d ov=%04b", i + 1, i, out_valid);
        end
        drive(2'd0, 1'b0, '0, 4'b1111);
        tick();
        check("stream_end_out_valid", 32'(out_valid), 32'h0);
        check("sb_empty_pre_reset", sb.size(), 0);

        // Async reset mid-cycle with channels 0 and 2 full; buffered words are discarded.
        drive(2'd0, 1'b1, 8'h5A, 4'b0000);
        tick();
        drive(2'd2, 1'b1, 8'h6B, 4'b0000);
        tick();
        drive(2'd0, 1'b0, '0, 4'b0000);
        check("pre_async_out_valid", 32'(out_valid), 32'h5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'h0);
        check("async_data", {od3, od2, od1, od0}, 32'h0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_async_in_ready", 32'(in_ready), 32'h1);
        $display("async reset: ov=%04b data=%08h", out_valid, {od3, od2, od1, od0});

`ifdef DEMUX_COUNT_EN
        // Counters saturate at 2^CW-1, and clear beats a same-cycle accept.
        for (int i = 0; i < 5; i++) begin
            drive(2'd1, 1'b1, 8'(8'h30 + i), 4'b0010);
            tick();
        end
        check("cnt1_saturated", 32'(cnt1), 32'h3);
        check("cnt_others", {cnt3, cnt2, cnt0}, 32'h0);
        clear_counts = 1'b1;
        drive(2'd1, 1'b1, 8'h40, 4'b0010);
        tick();
        clear_counts = 1'b0;
        check("cnt1_cleared", 32'(cnt1), 32'h0);
        drive(2'd1, 1'b0, '0, 4'b0010);
        tick();
        $display("counters: cnt1=%0d", cnt1);
`endif

        check("sb_empty_end", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
